// File: rtl/imul_varlat_param.sv
// rtl/imul_varlat_param.sv - variable-latency shift-add multiplier with capped multi-bit zero skipping
module imul_varlat_param #(
  parameter int NBITS    = 32,
  parameter int SKIP_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS-1:0] req_msg,
  input  logic [1:0]         req_mode,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [NBITS-1:0]   resp_msg
);

  localparam int SW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*NBITS-1:0]   a_reg, acc, acc_fin;
  logic [NBITS-1:0]     b_reg, msg_reg;
  logic [1:0]           mode_reg;
  logic                 neg;
  logic [NBITS-1:0]     a_in, b_in, a_mag, b_mag;
  logic                 a_sgn, b_sgn;
  logic [SW-1:0]        shamt;

  assign a_in  = req_msg[2*NBITS-1:NBITS];
  assign b_in  = req_msg[NBITS-1:0];
  assign a_sgn = ((req_mode == 2'b01) || (req_mode == 2'b11)) && a_in[NBITS-1];
  assign b_sgn = (req_mode == 2'b01) && b_in[NBITS-1];
  assign a_mag = a_sgn ? -a_in : a_in;
  assign b_mag = b_sgn ? -b_in : b_in;
  assign acc_fin = neg ? -acc : acc;

  // Step to the next set multiplier bit above bit 0, never more than SKIP_MAX positions.
  always_comb begin
    shamt = SW'(SKIP_MAX);
    for (int i = NBITS - 1; i >= 1; i--) begin
      if (b_reg[i]) shamt = SW'(i);
    end
    if (shamt > SW'(SKIP_MAX)) shamt = SW'(SKIP_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_val) state_nxt = CALC;
      CALC:    if (b_reg == '0) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    if (resp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_rdy  = (state == IDLE) && reset;
    resp_val = (state == DONE);
    resp_msg = msg_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      msg_reg  <= '0;
      mode_reg <= '0;
      neg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            mode_reg <= req_mode;
            a_reg    <= {{NBITS{1'b0}}, a_mag};
            b_reg    <= b_mag;
            neg      <= a_sgn ^ b_sgn;
            acc      <= '0;
          end
        end
        CALC: begin
          if (b_reg != '0) begin
            if (b_reg[0]) acc <= acc + a_reg;
            a_reg <= a_reg << shamt;
            b_reg <= b_reg >> shamt;
          end
        end
        SIGN: begin
          acc     <= acc_fin;
          msg_reg <= (mode_reg == 2'b00) ? acc_fin[NBITS-1:0] : acc_fin[2*NBITS-1:NBITS];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imul_varlat_param.sv
// tb/tb_imul_varlat_param.sv - table-driven scoreboard bench for imul_varlat_param
module tb_imul_varlat_param;

  logic        clk;
  logic        reset;
  logic [63:0] req_msg;
  logic [1:0]  req_mode;
  logic        req_val_v  [3];
  logic        req_rdy_v  [3];
  logic        resp_val_v [3];
  logic        resp_rdy_v [3];
  logic [31:0] resp_msg_v [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] msg;
    int          lat;
  } sb_t;

  vec_t vecs [13];
  sb_t  sb_q [$];

  imul_varlat_param #(.NBITS(32), .SKIP_MAX(8)) u_dut (
    .clk(clk), .reset(reset), .req_val(req_val_v[0]), .req_rdy(req_rdy_v[0]),
    .req_msg(req_msg), .req_mode(req_mode), .resp_val(resp_val_v[0]),
    .resp_rdy(resp_rdy_v[0]), .resp_msg(resp_msg_v[0]));

  imul_varlat_param #(.NBITS(32), .SKIP_MAX(1)) u_s1 (
    .clk(clk), .reset(reset), .req_val(req_val_v[1]), .req_rdy(req_rdy_v[1]),
    .req_msg(req_msg), .req_mode(req_mode), .resp_val(resp_val_v[1]),
    .resp_rdy(resp_rdy_v[1]), .resp_msg(resp_msg_v[1]));

  imul_varlat_param #(.NBITS(32), .SKIP_MAX(32)) u_s32 (
    .clk(clk), .reset(reset), .req_val(req_val_v[2]), .req_rdy(req_rdy_v[2]),
    .req_msg(req_msg), .req_mode(req_mode), .resp_val(resp_val_v[2]),
    .resp_rdy(resp_rdy_v[2]), .resp_msg(resp_msg_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_msg(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    logic [63:0] ax, bx, p;
    ax = (m == 2'b01 || m == 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    bx = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input logic [1:0] m, input int skip);
    logic [31:0] bm;
    int k, s;
    bm = (m == 2'b01 && b[31]) ? -b : b;
    k = 0;
    while (bm != 0) begin
      k++;
      if ((bm >> 1) == 0) s = skip;
      else begin
        s = 1;
        while (bm[s] == 1'b0) s++;
      end
      if (s > skip) s = skip;
      bm = bm >> s;
    end
    return k + 2;
  endfunction

  task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] mode, input logic [31:0] exp_msg,
                        input int exp_lat, input int hold);
    sb_t         e;
    int          n;
    logic [31:0] held;
    n = 0;
    while (!req_rdy_v[idx] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_rdy_before_accept", 64'(req_rdy_v[idx]), 64'd1);
    req_msg  = {a, b};
    req_mode = mode;
    req_val_v[idx] = 1'b1;
    sb_q.push_back('{exp_msg, exp_lat});
    @(posedge clk); #1;
    req_val_v[idx] = 1'b0;
    req_msg  = {$urandom, $urandom};
    req_mode = 2'($urandom);
    n = 0;
    while (!resp_val_v[idx] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    chk("resp_val_seen", 64'(resp_val_v[idx]), 64'd1);
    chk("latency", 64'(n), 64'(e.lat));
    chk("resp_msg", 64'(resp_msg_v[idx]), 64'(e.msg));
    held = resp_msg_v[idx];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_resp_val", 64'(resp_val_v[idx]), 64'd1);
      chk("hold_resp_msg", 64'(resp_msg_v[idx]), 64'(held));
      chk("hold_req_rdy", 64'(req_rdy_v[idx]), 64'd0);
    end
    resp_rdy_v[idx] = 1'b1;
    @(posedge clk); #1;
    resp_rdy_v[idx] = 1'b0;
    chk("idle_after_resp", {62'd0, resp_val_v[idx], req_rdy_v[idx]}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_val_v[i]  = 1'b0;
      resp_rdy_v[i] = 1'b0;
    end
    req_msg  = '0;
    req_mode = '0;
    reset    = 1'b0;

    vecs[0]  = '{32'd3,        32'd5,        2'b00, 32'h0000000F, 4};
    vecs[1]  = '{32'hDEADBEEF, 32'd0,        2'b00, 32'h00000000, 2};
    vecs[2]  = '{32'd0,        32'hFFFFFFFF, 2'b00, 32'h00000000, 34};
    vecs[3]  = '{32'hFFFFFFFE, 32'd3,        2'b00, 32'hFFFFFFFA, 4};
    vecs[4]  = '{32'hFFFFFFFE, 32'd3,        2'b01, 32'hFFFFFFFF, 4};
    vecs[5]  = '{32'hFFFFFFFE, 32'd3,        2'b10, 32'h00000002, 4};
    vecs[6]  = '{32'hFFFFFFFE, 32'd3,        2'b11, 32'hFFFFFFFF, 4};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFE, 34};
    vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h00000000, 3};
    vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFF, 34};
    vecs[10] = '{32'h80000000, 32'h80000000, 2'b01, 32'h40000000, 7};
    vecs[11] = '{32'd1,        32'h80000000, 2'b00, 32'h80000000, 7};
    vecs[12] = '{32'd7,        32'd6,        2'b00, 32'h0000002A, 5};

    #12;
    chk("reset_req_rdy", 64'(req_rdy_v[0]), 64'd0);
    chk("reset_resp_val", 64'(resp_val_v[0]), 64'd0);
    chk("reset_resp_msg", 64'(resp_msg_v[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_req_rdy", 64'(req_rdy_v[0]), 64'd1);

    foreach (vecs[i])
      do_txn(0, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp, vecs[i].lat, 0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rm;
      ra = $urandom;
      rb = (i < 3) ? ($urandom & 32'h00F00F01) : $urandom;
      rm = 2'($urandom_range(3));
      do_txn(0, ra, rb, rm, ref_msg(ra, rb, rm), ref_lat(rb, rm, 8), 0);
    end

    do_txn(1, 32'd1, 32'h80000000, 2'b00, 32'h80000000, 34, 0);
    do_txn(2, 32'd1, 32'h80000000, 2'b00, 32'h80000000, 4, 0);

    do_txn(0, 32'h12345678, 32'h9ABCDEF0, 2'b10,
           ref_msg(32'h12345678, 32'h9ABCDEF0, 2'b10), ref_lat(32'h9ABCDEF0, 2'b10, 8), 3);

    // Abort mid-CALC: long multiplier keeps the block busy.
    req_msg  = {32'd5, 32'hFFFFFFFF};
    req_mode = 2'b00;
    req_val_v[0] = 1'b1;
    @(posedge clk); #1;
    req_val_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_calc_resp_val", 64'(resp_val_v[0]), 64'd0);
    chk("abort_calc_req_rdy", 64'(req_rdy_v[0]), 64'd0);
    chk("abort_calc_resp_msg", 64'(resp_msg_v[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_calc_rdy_after", 64'(req_rdy_v[0]), 64'd1);
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_val_v[0]) break;
    end
    chk("abort_calc_no_resp", 64'(resp_val_v[0]), 64'd0);

    // Abort while a response is waiting in DONE.
    req_msg  = {32'd2, 32'd2};
    req_mode = 2'b00;
    req_val_v[0] = 1'b1;
    @(posedge clk); #1;
    req_val_v[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("done_before_abort", 64'(resp_val_v[0]), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_done_resp_val", 64'(resp_val_v[0]), 64'd0);
    chk("abort_done_req_rdy", 64'(req_rdy_v[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_done_rdy_after", 64'(req_rdy_v[0]), 64'd1);

    do_txn(0, 32'd7, 32'd6, 2'b00, 32'h0000002A, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
